// File: rtl/ysyx_23060184_clint.sv
// Core-local interruptor: a free-running 64-bit mtime, a 64-bit mtimecmp and
// the registered machine timer interrupt, exposed as an AXI4-lite-style
// responder on the shared data-side bus. Reads and writes run in independent
// FSMs and only respond when the data master is granted and the address is
// inside the 0xC000-byte window.
module ysyx_23060184_clint #(
  parameter logic [31:0] BASE            = 32'h0200_0000,
  parameter int          TICK_DIV        = 1,
  parameter int          GRANT_BIT       = 1,
  parameter int          NUM_ARB_MASTERS = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_ARB_MASTERS-1:0] grant,
  input  logic [31:0]                araddr,
  input  logic                       arvalid,
  output logic                       aready,
  output logic [31:0]                rdata,
  output logic [1:0]                 rresp,
  output logic                       rvalid,
  input  logic                       rready,
  input  logic [31:0]                awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [31:0]                wdata,
  input  logic [3:0]                 wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  output logic                       mtip
);

  localparam logic [31:0] WIN_SIZE = 32'h0000_C000;
  localparam logic [1:0]  RESP_OK  = 2'b00;
  localparam logic [1:0]  RESP_DEC = 2'b11;

  // Word indices (offset >> 2) of the mapped registers.
  localparam logic [13:0] IDX_CMP_LO = 14'h1000;  // 0x4000
  localparam logic [13:0] IDX_CMP_HI = 14'h1001;  // 0x4004
  localparam logic [13:0] IDX_MT_LO  = 14'h2FFE;  // 0xBFF8
  localparam logic [13:0] IDX_MT_HI  = 14'h2FFF;  // 0xBFFC

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic { R_IDLE, R_RESP } rd_state_t;
  typedef enum logic { W_IDLE, W_RESP } wr_state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [63:0]   mtime_reg;
  logic [63:0]   mtimecmp_reg;
  logic [PW-1:0] prescaler_reg;
  logic          mtip_reg;

  rd_state_t     rd_state_reg, rd_state_next;
  logic [31:0]   rdata_reg;
  logic [1:0]    rresp_reg;

  wr_state_t     wr_state_reg, wr_state_next;
  logic          aw_got_reg;
  logic          w_got_reg;
  logic [13:0]   aw_idx_reg;
  logic [31:0]   wdata_reg;
  logic [3:0]    wstrb_reg;
  logic [1:0]    bresp_reg;

  // Only the data-master bit of grant matters here.
  logic unused_grant;
  assign unused_grant = ^grant;

  logic granted;
  assign granted = grant[GRANT_BIT];

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [31:0] rd_off, aw_off;
  logic        rd_in_win, aw_in_win;
  logic        rd_sel, wr_sel;
  logic [13:0] rd_idx;

  assign rd_off    = araddr - BASE;
  assign aw_off    = awaddr - BASE;
  assign rd_in_win = (araddr >= BASE) && (rd_off < WIN_SIZE);
  assign aw_in_win = (awaddr >= BASE) && (aw_off < WIN_SIZE);
  assign rd_sel    = granted & rd_in_win;
  assign wr_sel    = granted & aw_in_win;
  assign rd_idx    = rd_off[15:2];

  // Register file read mux, always sampling pre-edge values.
  logic [31:0] rd_word;
  logic [1:0]  rd_word_resp;

  // Select the register addressed by araddr; unmapped offsets give DECERR and zero.
  always_comb begin
    rd_word      = 32'h0;
    rd_word_resp = RESP_DEC;
    case (rd_idx)
      IDX_CMP_LO: begin rd_word = mtimecmp_reg[31:0];  rd_word_resp = RESP_OK; end
      IDX_CMP_HI: begin rd_word = mtimecmp_reg[63:32]; rd_word_resp = RESP_OK; end
      IDX_MT_LO:  begin rd_word = mtime_reg[31:0];     rd_word_resp = RESP_OK; end
      IDX_MT_HI:  begin rd_word = mtime_reg[63:32];    rd_word_resp = RESP_OK; end
      default:    ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Write channel handshakes and commit
  // ---------------------------------------------------------------------
  logic        aw_hs, w_hs, commit;
  logic [13:0] cm_idx;
  logic [31:0] cm_data;
  logic [3:0]  cm_strb;
  logic [31:0] cm_mask;
  logic        cm_mapped;
  logic        wr_cmp_lo, wr_cmp_hi, wr_mt_lo, wr_mt_hi;

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  // The commit happens on whichever edge completes the second handshake.
  assign commit = (wr_state_reg == W_IDLE) & (aw_got_reg | aw_hs) & (w_got_reg | w_hs);

  assign cm_idx  = aw_got_reg ? aw_idx_reg : aw_off[15:2];
  assign cm_data = w_got_reg  ? wdata_reg  : wdata;
  assign cm_strb = w_got_reg  ? wstrb_reg  : wstrb;

  // Expand byte strobes into a bit mask for the read-modify-write merge.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane_mask
      assign cm_mask[8*gi +: 8] = {8{cm_strb[gi]}};
    end
  endgenerate

  assign wr_cmp_lo = commit & (cm_idx == IDX_CMP_LO);
  assign wr_cmp_hi = commit & (cm_idx == IDX_CMP_HI);
  assign wr_mt_lo  = commit & (cm_idx == IDX_MT_LO);
  assign wr_mt_hi  = commit & (cm_idx == IDX_MT_HI);
  assign cm_mapped = (cm_idx == IDX_CMP_LO) | (cm_idx == IDX_CMP_HI) |
                     (cm_idx == IDX_MT_LO)  | (cm_idx == IDX_MT_HI);

  function automatic logic [31:0] merge(input logic [31:0] old_word,
                                        input logic [31:0] new_word,
                                        input logic [31:0] mask);
    return (old_word & ~mask) | (new_word & mask);
  endfunction

  // ---------------------------------------------------------------------
  // Timer
  // ---------------------------------------------------------------------
  logic tick;
  assign tick = (prescaler_reg == PW'(TICK_DIV - 1));

  // Prescaler cycles 0..TICK_DIV-1; mtime advances on its terminal count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prescaler_reg <= '0;
    end else if (tick) begin
      prescaler_reg <= '0;
    end else begin
      prescaler_reg <= prescaler_reg + PW'(1);
    end
  end

  // mtime: a bus write wins over the increment on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtime_reg <= 64'h0;
    end else if (wr_mt_lo) begin
      mtime_reg[31:0] <= merge(mtime_reg[31:0], cm_data, cm_mask);
    end else if (wr_mt_hi) begin
      mtime_reg[63:32] <= merge(mtime_reg[63:32], cm_data, cm_mask);
    end else if (tick) begin
      mtime_reg <= mtime_reg + 64'd1;
    end
  end

  // mtimecmp: byte-merged writes to either word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtimecmp_reg <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      if (wr_cmp_lo) mtimecmp_reg[31:0]  <= merge(mtimecmp_reg[31:0], cm_data, cm_mask);
      if (wr_cmp_hi) mtimecmp_reg[63:32] <= merge(mtimecmp_reg[63:32], cm_data, cm_mask);
    end
  end

  // Interrupt compares the pre-edge registers, so it lags by one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtip_reg <= 1'b0;
    end else begin
      mtip_reg <= (mtime_reg >= mtimecmp_reg);
    end
  end

  assign mtip = mtip_reg;

  // ---------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------
  // Read state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state_reg <= R_IDLE;
    end else begin
      rd_state_reg <= rd_state_next;
    end
  end

  // Read next-state and handshake outputs.
  always_comb begin
    rd_state_next = rd_state_reg;
    aready        = 1'b0;
    rvalid        = 1'b0;
    case (rd_state_reg)
      R_IDLE: begin
        aready = rd_sel;
        if (arvalid && rd_sel) rd_state_next = R_RESP;
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) rd_state_next = R_IDLE;
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  // Capture read data and response on the AR handshake and hold them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_reg <= 32'h0;
      rresp_reg <= RESP_OK;
    end else if (rd_state_reg == R_IDLE && arvalid && aready) begin
      rdata_reg <= rd_word;
      rresp_reg <= rd_word_resp;
    end
  end

  assign rdata = rdata_reg;
  assign rresp = rresp_reg;

  // ---------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------
  // Write state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state_reg <= W_IDLE;
    end else begin
      wr_state_reg <= wr_state_next;
    end
  end

  // Write next-state and handshake outputs; W may arrive before, with or after AW.
  always_comb begin
    wr_state_next = wr_state_reg;
    awready       = 1'b0;
    wready        = 1'b0;
    bvalid        = 1'b0;
    case (wr_state_reg)
      W_IDLE: begin
        awready = ~aw_got_reg & wr_sel;
        wready  = ~w_got_reg & granted & (aw_got_reg | (awvalid & aw_in_win));
        if (commit) wr_state_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) wr_state_next = W_IDLE;
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  // Latch each channel on its own handshake; record the response at commit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_got_reg <= 1'b0;
      w_got_reg  <= 1'b0;
      aw_idx_reg <= 14'h0;
      wdata_reg  <= 32'h0;
      wstrb_reg  <= 4'h0;
      bresp_reg  <= RESP_OK;
    end else if (wr_state_reg == W_IDLE) begin
      if (aw_hs) begin
        aw_got_reg <= 1'b1;
        aw_idx_reg <= aw_off[15:2];
      end
      if (w_hs) begin
        w_got_reg <= 1'b1;
        wdata_reg <= wdata;
        wstrb_reg <= wstrb;
      end
      if (commit) bresp_reg <= cm_mapped ? RESP_OK : RESP_DEC;
    end else if (bready) begin
      aw_got_reg <= 1'b0;
      w_got_reg  <= 1'b0;
    end
  end

  assign bresp = bresp_reg;

endmodule

// File: tb/tb_ysyx_23060184_clint.sv
// Directed bench for the CLINT: a vector table of register transactions plus
// hand-written sequences for timing, carry, interrupt, grant/window and reset.
module tb_ysyx_23060184_clint;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  grant = 2'b00;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        aready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic        mtip;

  ysyx_23060184_clint #(
    .BASE(BASE), .TICK_DIV(1), .GRANT_BIT(1), .NUM_ARB_MASTERS(2)
  ) dut (
    .clk(clk), .rstn(rstn), .grant(grant),
    .araddr(araddr), .arvalid(arvalid), .aready(aready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .mtip(mtip)
  );

  always #5 clk = ~clk;

  // Edge counter: after the n-th rising edge it reads n.
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int   checks = 0;
  int   errors = 0;
  logic mtip_at_commit;

  typedef struct {
    logic        wr;
    logic [15:0] off;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int hs_edge);
    int n;
    n = 0;
    araddr  = addr;
    arvalid = 1'b1;
    #1;
    while (!aready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("rd_aready", aready, 1);
    @(posedge clk); @(negedge clk);
    hs_edge = edge_cnt;
    chk("rd_rvalid_latency", rvalid, 1);
    data    = rdata;
    resp    = rresp;
    arvalid = 1'b0;
    rready  = 1'b1;
    @(posedge clk); @(negedge clk);
    rready = 1'b0;
    #1 chk("rd_rvalid_drop", rvalid, 0);
    $display("read  addr=%h data=%h resp=%0d edge=%0d", addr, data, resp, hs_edge);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp,
                          output int cm_edge);
    int n;
    n = 0;
    awaddr  = addr;
    awvalid = 1'b1;
    wdata   = data;
    wstrb   = strb;
    wvalid  = 1'b1;
    #1;
    while (!(awready && wready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("wr_ready", {awready, wready}, 2'b11);
    @(posedge clk); @(negedge clk);
    cm_edge = edge_cnt;
    chk("wr_bvalid_latency", bvalid, 1);
    resp           = bresp;
    mtip_at_commit = mtip;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    #1 chk("wr_bvalid_drop", bvalid, 0);
    $display("write addr=%h data=%h strb=%b resp=%0d edge=%0d", addr, data, strb, resp, cm_edge);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          h, c, rel, n;
    logic [63:0] m_base;
    int          m_edge;
    logic [63:0] v;

    // Register transaction vectors (mtimecmp_lo = FFFFCCDD after the split write).
    vt[0]  = '{1'b0, 16'h4000, 32'h0,        4'h0, 32'hFFFF_CCDD, 2'd0};
    vt[1]  = '{1'b0, 16'h4004, 32'h0,        4'h0, 32'hFFFF_FFFF, 2'd0};
    vt[2]  = '{1'b1, 16'h4004, 32'h1122_3344, 4'hC, 32'h0,        2'd0};
    vt[3]  = '{1'b0, 16'h4004, 32'h0,        4'h0, 32'h1122_FFFF, 2'd0};
    vt[4]  = '{1'b1, 16'h4004, 32'h0,        4'h3, 32'h0,         2'd0};
    vt[5]  = '{1'b0, 16'h4006, 32'h0,        4'h0, 32'h1122_0000, 2'd0};
    vt[6]  = '{1'b0, 16'h0010, 32'h0,        4'h0, 32'h0,         2'd3};
    vt[7]  = '{1'b1, 16'h0010, 32'h1234_5678, 4'hF, 32'h0,        2'd3};
    vt[8]  = '{1'b0, 16'h4000, 32'h0,        4'h0, 32'hFFFF_CCDD, 2'd0};
    vt[9]  = '{1'b1, 16'h4007, 32'hAB00_0000, 4'h8, 32'h0,        2'd0};
    vt[10] = '{1'b0, 16'h4004, 32'h0,        4'h0, 32'hAB22_0000, 2'd0};
    vt[11] = '{1'b0, 16'hBFF4, 32'h0,        4'h0, 32'h0,         2'd3};
    vt[12] = '{1'b1, 16'h4004, 32'h0,        4'hF, 32'h0,         2'd0};
    vt[13] = '{1'b0, 16'h4004, 32'h0,        4'h0, 32'h0,         2'd0};

    // ---- Reset state ----
    @(negedge clk);
    #1;
    chk("reset_rvalid", rvalid, 0);
    chk("reset_bvalid", bvalid, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_resps", {rresp, bresp}, 0);
    chk("reset_mtip", mtip, 0);
    @(negedge clk);
    grant = 2'b10;
    rstn  = 1'b1;
    rel   = edge_cnt;

    // ---- First read: mtime counts cycles since release ----
    repeat (10) @(posedge clk);
    @(negedge clk);
    do_read(BASE + 32'hBFF8, d, r, h);
    chk("first_read_mtime", d, 32'd10);
    chk("first_read_formula", d, 32'(h - 1 - rel));
    chk("first_read_rresp", r, 2'b00);
    chk("first_read_mtip", mtip, 0);

    // ---- Split AW then W with strobes, delayed bready ----
    @(negedge clk);
    awaddr  = BASE + 32'h4000;
    awvalid = 1'b1;
    #1 chk("split_awready", awready, 1);
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    #1 chk("split_awready_after_hs", awready, 0);
    repeat (3) @(negedge clk);
    wdata  = 32'hAABB_CCDD;
    wstrb  = 4'b0011;
    wvalid = 1'b1;
    #1 chk("split_wready", wready, 1);
    chk("split_bvalid_before", bvalid, 0);
    @(posedge clk); @(negedge clk);
    wvalid = 1'b0;
    chk("split_bvalid_rise", bvalid, 1);
    chk("split_bresp", bresp, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("split_bvalid_hold%0d", i), {bvalid, bresp}, 3'b100);
    end
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    #1 chk("split_bvalid_drop", bvalid, 0);
    $display("write addr=%h data=aabbccdd strb=0011 split", BASE + 32'h4000);

    // ---- Vector table ----
    for (int i = 0; i < 14; i++) begin
      if (vt[i].wr) begin
        do_write(BASE + {16'h0, vt[i].off}, vt[i].data, vt[i].strb, r, c);
        chk($sformatf("vec%0d_bresp", i), r, vt[i].exp_resp);
      end else begin
        do_read(BASE + {16'h0, vt[i].off}, d, r, h);
        chk($sformatf("vec%0d_rdata", i), d, vt[i].exp_data);
        chk($sformatf("vec%0d_rresp", i), r, vt[i].exp_resp);
      end
    end
    chk("table_mtip", mtip, 0);

    // ---- Interrupt ----
    do_write(BASE + 32'hBFFC, 32'h0, 4'hF, r, c);
    do_write(BASE + 32'hBFF8, 32'h20, 4'hF, r, c);
    m_base = 64'h20;
    m_edge = c;
    do_write(BASE + 32'h4004, 32'h0, 4'hF, r, c);
    do_write(BASE + 32'h4000, 32'h40, 4'hF, r, c);
    chk("irq_not_yet", mtip, 0);
    n = 0;
    while (edge_cnt < m_edge + 32 && n < 200) begin
      @(negedge clk); n++;
    end
    chk("irq_wait_bound", edge_cnt, m_edge + 32);
    chk("irq_at_0x40_edge", mtip, 0);
    @(negedge clk);
    chk("irq_one_cycle_after", mtip, 1);
    do_write(BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF, r, c);
    chk("irq_lag_at_commit", mtip_at_commit, 1);
    chk("irq_deassert", mtip, 0);

    // ---- Carry from low to high word ----
    do_write(BASE + 32'hBFFC, 32'h0, 4'hF, r, c);
    do_write(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, r, c);
    m_base = 64'h0000_0000_FFFF_FFFF;
    m_edge = c;
    do_read(BASE + 32'hBFFC, d, r, h);
    chk("carry_hi", d, 32'd1);
    do_read(BASE + 32'hBFF8, d, r, h);
    v = m_base + 64'(h - 1 - m_edge);
    chk("carry_lo", d, v[31:0]);

    // ---- Write mtime_lo=5 with a same-cycle read (read sees pre-commit value) ----
    @(negedge clk);
    araddr  = BASE + 32'hBFF8;
    arvalid = 1'b1;
    awaddr  = BASE + 32'hBFF8;
    wdata   = 32'd5;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    #1 chk("prec_readies", {aready, awready, wready}, 3'b111);
    @(posedge clk); @(negedge clk);
    c = edge_cnt;
    v = m_base + 64'(c - 1 - m_edge);
    chk("prec_resp_valids", {rvalid, bvalid}, 2'b11);
    chk("prec_read_pre_commit", rdata, v[31:0]);
    m_base = {v[63:32], 32'd5};
    m_edge = c;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rready  = 1'b1; bready  = 1'b1;
    @(posedge clk); @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    do_read(BASE + 32'hBFF8, d, r, h);
    v = m_base + 64'(h - 1 - m_edge);
    chk("prec_read_5_plus", d, v[31:0]);
    do_read(BASE + 32'hBFF8, d, r, h);
    v = m_base + 64'(h - 1 - m_edge);
    chk("prec_increments", d, v[31:0]);

    // ---- Grant gating ----
    @(negedge clk);
    grant   = 2'b01;
    araddr  = BASE + 32'hBFF8;
    arvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk($sformatf("nogrant_aready%0d", i), aready, 0);
    end
    grant = 2'b10;
    #1 chk("grant_aready", aready, 1);
    @(posedge clk); @(negedge clk);
    chk("grant_rvalid", rvalid, 1);
    arvalid = 1'b0;
    rready  = 1'b1;
    @(posedge clk); @(negedge clk);
    rready = 1'b0;

    // ---- Window boundaries ----
    araddr  = BASE + 32'hC000;
    awaddr  = BASE + 32'hC000;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk($sformatf("outwin_readies%0d", i), {aready, awready, wready}, 3'b000);
    end
    araddr = BASE - 32'd4;
    awaddr = BASE - 32'd4;
    #1 chk("below_base_readies", {aready, awready, wready}, 3'b000);
    @(negedge clk);
    chk("outwin_no_resp", {rvalid, bvalid}, 2'b00);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;

    // ---- Asynchronous reset during R_RESP ----
    @(negedge clk);
    araddr  = BASE + 32'hBFF8;
    arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_mid_rvalid_before", rvalid, 1);
    arvalid = 1'b0;
    #2 rstn = 1'b0;
    #1 chk("rst_mid_rvalid_async", rvalid, 0);
    chk("rst_mid_mtip", mtip, 0);
    @(negedge clk);
    chk("rst_mid_rvalid_held", rvalid, 0);
    rstn = 1'b1;
    rel  = edge_cnt;
    do_read(BASE + 32'hBFF8, d, r, h);
    chk("rst_mid_mtime_restart", d, 32'(h - 1 - rel));
    chk("rst_mid_rresp", r, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060184_clint.md
Name: ysyx_23060184_clint

Overview:
- AXI4-lite-style responder on the shared data-side bus, alongside SRAM and UART.
- Holds a free-running 64-bit machine timer (mtime) and a 64-bit compare register (mtimecmp).
- Drives the machine timer interrupt line mtip.
- Answers MEMU loads and stores only when the arbiter grants the data master and the address falls in its window.

Parameters:
- BASE, 32'h0200_0000, base address of the window; window size is 0xC000 bytes.
- TICK_DIV, 1, clock cycles per mtime increment (>=1).
- GRANT_BIT, 1, index of the data-master bit in grant.
- NUM_ARB_MASTERS, 2, width of grant.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- grant  in  NUM_ARB_MASTERS  arbiter grant vector.
- araddr  in  32  read address.
- arvalid  in  1  read address valid.
- aready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response: 00 OKAY, 11 DECERR.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- awaddr  in  32  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  byte strobes.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response: 00 OKAY, 11 DECERR.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- mtip  out  1  timer interrupt, registered.

Behaviour:
- Reset (rstn=0, asynchronous):
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, mtip=0.
  - Read FSM in R_IDLE, write FSM in W_IDLE, capture flags cleared.
  - rvalid=bvalid=0, rdata=0, rresp=bresp=00.
  - Reset mid-transaction discards it; no response is issued.
- Register map (offset from BASE, 32-bit words):
  - 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
  - Any other in-window offset is unmapped: DECERR, read data 0, writes ignored.
  - Address bits [1:0] are ignored.
- Selection:
  - in_win(a) = BASE <= a < BASE+0xC000.
  - Read selected = grant[GRANT_BIT] & in_win(araddr).
  - Write selected = grant[GRANT_BIT] & in_win(awaddr).
  - When not selected, aready, awready and wready are 0, leaving the transfer to other responders.
- Timer:
  - Prescaler counts 0..TICK_DIV-1.
  - mtime increments by 1 on the edge where prescaler==TICK_DIV-1; with TICK_DIV=1 that is every cycle.
  - Carry from bit 31 propagates to bit 32; mtime wraps from 2^64-1 to 0.
  - A write to either mtime word on a tick edge takes precedence: the written value is loaded and there is no increment on that edge.
  - mtip <= (mtime >= mtimecmp), unsigned 64-bit compare, registered (one cycle lag).
- Read FSM:
  - R_IDLE:
    - aready=1 when read selected.
    - On arvalid&aready: latch rdata/rresp from current register values (pre-edge), go to R_RESP.
  - R_RESP:
    - rvalid=1; rdata and rresp held stable.
    - On rready: go to R_IDLE.
    - aready=0 while in R_RESP.
  - Latency: rvalid rises the cycle after the AR handshake; back-to-back reads take a minimum of 2 cycles each.
- Write FSM:
  - W_IDLE:
    - awready = ~aw_got & write selected.
    - wready = ~w_got & grant[GRANT_BIT] & (aw_got | (awvalid & in_win(awaddr))).
    - AW and W handshake in either order or in the same cycle; each is latched on its handshake.
  - Commit:
    - Occurs on the edge where the second handshake completes.
    - Byte-lane merge: byte i is updated only if wstrb[i]=1.
    - Unmapped offset: no state change, bresp=11; otherwise bresp=00.
    - FSM then moves to W_RESP.
  - W_RESP:
    - bvalid=1 (rises the cycle after commit); bresp held.
    - On bready: clear flags, go to W_IDLE.
- Concurrency:
  - Read and write FSMs are independent.
  - A read in the same cycle as a write commit returns the pre-commit value.
- mtimecmp commit vs. interrupt:
  - A commit of mtimecmp on a tick edge is compared against the updated mtime on the next edge.
  - mtip may deassert one cycle after the commit.

Test Plan:
- Reset, TICK_DIV=1:
  - Stimulus: release rstn, wait 10 cycles, read BASE+0xBFF8.
  - Required: aready=1, rvalid exactly 1 cycle after handshake, rresp=00, rdata = cycles from release to handshake (10), mtip=0.
- Split write with strobes:
  - Stimulus: AW to BASE+0x4000, then W 3 cycles later with wdata=0xAABBCCDD, wstrb=4'b0011; hold bready=0 for 5 cycles.
  - Required: mtimecmp[31:0]=0xFFFFCCDD; bvalid rises 1 cycle after W handshake and holds with bresp=00 until bready.
- Interrupt:
  - Stimulus: write mtimecmp_hi=0 then mtimecmp_lo=0x40.
  - Required: mtip=1 exactly one cycle after mtime reaches 0x40.
  - Stimulus: then write mtimecmp_lo=0xFFFFFFFF.
  - Required: mtip returns to 0.
- Carry and precedence:
  - Stimulus: write mtime_hi=0, then mtime_lo=0xFFFFFFFF.
  - Required: next tick gives hi=1, lo=0.
  - Stimulus: write mtime_lo=5 on a tick edge.
  - Required: reads back 5, then increments.
- Unmapped offset:
  - Stimulus: read BASE+0x0010.
  - Required: rresp=11, rdata=0.
  - Stimulus: write 0x12345678 there.
  - Required: bresp=11; mtime and mtimecmp unchanged.
- Grant, window and reset:
  - Stimulus: arvalid in window with grant[1]=0.
  - Required: aready=0 until grant[1]=1.
  - Stimulus: address BASE+0xC000.
  - Required: no ready ever asserted.
  - Stimulus: rstn=0 while in R_RESP.
  - Required: rvalid=0 immediately (asynchronous) and the FSM is in R_IDLE after release.
